// File: rtl/stream_pkg.sv
// Shared definitions for the stream multiplexer family.
//   MODE_SELECT / MODE_RR : values for the MODE parameter of stream_mux_arb
//   clog2()               : index-width helper usable in parameter expressions
package stream_pkg;

    localparam int unsigned MODE_SELECT = 0;
    localparam int unsigned MODE_RR     = 1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting lane found by a cyclic
// search that starts one lane after ptr_i.
//   req_i     : per-lane request vector
//   ptr_i     : index of the most recently granted lane
//   en_i      : when low, no grant is issued
//   gnt_o     : one-hot grant, all zero when nothing is granted
//   gnt_idx_o : binary index of the granted lane (0 when no grant)
module rr_arbiter
    import stream_pkg::*;
#(
    parameter  int unsigned NUM_IN    = 4,
    localparam int unsigned SEL_WIDTH = clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0]    req_i,
    input  logic [SEL_WIDTH-1:0] ptr_i,
    input  logic                 en_i,
    output logic [NUM_IN-1:0]    gnt_o,
    output logic [SEL_WIDTH-1:0] gnt_idx_o
);

    logic                 found;
    logic [SEL_WIDTH:0]   sum;
    logic [SEL_WIDTH-1:0] lane;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        sum       = '0;
        lane      = '0;
        // k = NUM_IN revisits ptr_i itself, so a lone requester on the last
        // granted lane is still served.
        for (int k = 1; k <= int'(NUM_IN); k++) begin
            sum = {1'b0, ptr_i} + (SEL_WIDTH+1)'(k);
            if (sum >= (SEL_WIDTH+1)'(NUM_IN)) begin
                sum = sum - (SEL_WIDTH+1)'(NUM_IN);
            end
            lane = sum[SEL_WIDTH-1:0];
            if (en_i && !found && req_i[lane]) begin
                found       = 1'b1;
                gnt_o[lane] = 1'b1;
                gnt_idx_o   = lane;
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-to-1 stream multiplexer with a registered output stage and valid/ready
// handshaking on every lane. MODE_SELECT routes the lane named by Selector;
// MODE_RR arbitrates round-robin among valid lanes.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   Selector   : chosen lane (MODE_SELECT only)
//   In_Data    : flattened lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   In_Valid   : per-lane valid
//   In_Ready   : per-lane ready, at most one bit set
//   Out_Data   : registered data word
//   Out_Source : lane that produced Out_Data
//   Out_Valid  : Out_Data holds a word
//   Out_Ready  : consumer accepts the word
module stream_mux_arb
    import stream_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned NUM_IN     = 4,
    parameter  int unsigned MODE       = MODE_SELECT,
    localparam int unsigned SEL_WIDTH  = clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SEL_WIDTH-1:0]         Selector,
    input  logic [NUM_IN*DATA_WIDTH-1:0] In_Data,
    input  logic [NUM_IN-1:0]            In_Valid,
    output logic [NUM_IN-1:0]            In_Ready,
    output logic [DATA_WIDTH-1:0]        Out_Data,
    output logic [SEL_WIDTH-1:0]         Out_Source,
    output logic                         Out_Valid,
    input  logic                         Out_Ready
);

    logic                  load_en;
    logic                  xfer;
    logic [NUM_IN-1:0]     cand_onehot;  // all zero when there is no candidate
    logic [SEL_WIDTH-1:0]  cand_idx;
    logic [DATA_WIDTH-1:0] lane_data;

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0]  out_source_q, out_source_d;
    logic                  out_valid_q, out_valid_d;

    assign load_en = ~out_valid_q | Out_Ready;

    if (MODE == MODE_RR) begin : g_rr
        logic [SEL_WIDTH-1:0] ptr_q, ptr_d;

        rr_arbiter #(
            .NUM_IN (NUM_IN)
        ) u_rr_arbiter (
            .req_i     (In_Valid),
            .ptr_i     (ptr_q),
            .en_i      (load_en),
            .gnt_o     (cand_onehot),
            .gnt_idx_o (cand_idx)
        );

        always_comb begin
            ptr_d = ptr_q;
            if (xfer) begin
                ptr_d = cand_idx;
            end
        end

        // Reset to the last lane so the first search begins at lane 0.
        always_ff @(posedge clk) begin
            if (reset) begin
                ptr_q <= SEL_WIDTH'(NUM_IN - 1);
            end else begin
                ptr_q <= ptr_d;
            end
        end
    end else begin : g_sel
        // An out-of-range Selector decodes to no candidate.
        always_comb begin
            cand_idx    = Selector;
            cand_onehot = '0;
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (Selector == SEL_WIDTH'(i)) begin
                    cand_onehot[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        In_Ready = '0;
        if (load_en && !reset) begin
            In_Ready = cand_onehot;
        end
    end

    assign xfer = |(In_Valid & In_Ready);

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (cand_onehot[i]) begin
                lane_data = In_Data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        out_data_d   = out_data_q;
        out_source_d = out_source_q;
        out_valid_d  = out_valid_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d   = lane_data;
                out_source_d = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q   <= '0;
            out_source_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_source_q <= out_source_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign Out_Data   = out_data_q;
    assign Out_Source = out_source_q;
    assign Out_Valid  = out_valid_q;

endmodule
